// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N systolic matmul: operand fetch, edge skew, init wavefronts, result drain.
// Optional drain watchdog is built when SYS_SEQ_CTRL_WATCHDOG_EN is defined.
module systolic_seq_ctrl #(
  parameter int D_W    = 8,
  parameter int N      = 4,
  parameter int K_MAX  = 256,
  parameter int AW     = 8,
  parameter int TO_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  output logic                         rd_en,
  output logic [AW-1:0]                a_addr,
  output logic [AW-1:0]                b_addr,
  input  logic [N*D_W-1:0]             a_rd_data,
  input  logic [N*D_W-1:0]             b_rd_data,
  output logic [N*D_W-1:0]             a_edge,
  output logic [N*D_W-1:0]             b_edge,
  output logic [N*N-1:0]               init_vec,
  input  logic [N-1:0]                 res_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int KW = $clog2(K_MAX+1);
  localparam int YW = KW + 1;
  localparam int CW = $clog2(N*N+1);
  localparam int NS = 2*N - 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q, fcnt_q;
  logic [YW-1:0]   cyc_q;
  logic [CW-1:0]   rcnt_q;
  logic            rd_en_q, rvld_q, busy_q, done_q;
  logic [NS-1:0]   wave_q;

  logic [CW-1:0]   pop_d;
  logic [CW:0]     rsum_d;
  logic [CW-1:0]   rcnt_d;
  logic            armed_d, inj_d, full_d;

`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
  localparam int WW = $clog2(TO_CYC+1);
  logic [WW-1:0]   wd_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // cyc_q equals the cycle index after accept; results count only from the flush wavefront on.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < N; i++) pop_d = pop_d + CW'(res_valid[i]);
    rsum_d  = {1'b0, rcnt_q} + {1'b0, pop_d};
    rcnt_d  = (rsum_d >= (CW+1)'(N*N)) ? CW'(N*N) : rsum_d[CW-1:0];
    full_d  = (rcnt_d == CW'(N*N));
    armed_d = (cyc_q >= ({1'b0, k_q} + YW'(3)));
    inj_d   = ((state_q == FETCH) || (state_q == DRAIN)) &&
              ((cyc_q == YW'(2)) || (cyc_q == ({1'b0, k_q} + YW'(2))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      fcnt_q  <= '0;
      cyc_q   <= '0;
      rcnt_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
      err_q  <= 1'b0;
`endif
      if ((state_q == FETCH || state_q == DRAIN) && cyc_q != '1) cyc_q <= cyc_q + YW'(1);
      case (state_q)
        IDLE: if (start) begin
          k_q    <= k_len;
          fcnt_q <= '0;
          rcnt_q <= '0;
          cyc_q  <= YW'(1);
          busy_q <= 1'b1;
`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
          wd_q   <= '0;
`endif
          if (k_len != '0) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (fcnt_q == k_q - KW'(1)) begin
            rd_en_q <= 1'b0;
            fcnt_q  <= '0;
            state_q <= DRAIN;
          end else begin
            fcnt_q <= fcnt_q + KW'(1);
          end
        end
        DRAIN: begin
          if (armed_d) rcnt_q <= rcnt_d;
`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
          if (err_q || (armed_d && full_d)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (|res_valid) begin
            wd_q <= '0;
          end else begin
            wd_q <= wd_q + WW'(1);
            if (wd_q == WW'(TO_CYC-1)) err_q <= 1'b1;
          end
`else
          if (armed_d && full_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cyc_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Zeroing the capture outside the read window gives zero operands during the flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvld_q <= 1'b0;
      wave_q <= '0;
    end else begin
      rvld_q <= rd_en_q;
      wave_q <= {wave_q[NS-2:0], inj_d};
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [D_W-1:0] a_dly_q [0:gi];
      logic [D_W-1:0] b_dly_q [0:gi];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s <= gi; s++) begin
            a_dly_q[s] <= '0;
            b_dly_q[s] <= '0;
          end
        end else begin
          a_dly_q[0] <= rvld_q ? a_rd_data[gi*D_W +: D_W] : '0;
          b_dly_q[0] <= rvld_q ? b_rd_data[gi*D_W +: D_W] : '0;
          for (int s = 1; s <= gi; s++) begin
            a_dly_q[s] <= a_dly_q[s-1];
            b_dly_q[s] <= b_dly_q[s-1];
          end
        end
      end
      assign a_edge[gi*D_W +: D_W] = a_dly_q[gi];
      assign b_edge[gi*D_W +: D_W] = b_dly_q[gi];
      for (genvar gj = 0; gj < N; gj++) begin : g_col
        assign init_vec[gi*N+gj] = wave_q[gi+gj];
      end
    end
  endgenerate

  assign rd_en  = rd_en_q;
  assign a_addr = AW'(fcnt_q);
  assign b_addr = AW'(fcnt_q);
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized bench for systolic_seq_ctrl against a cycle-indexed model of fetch, skew, wavefronts and drain.
module tb_systolic_seq_ctrl;
  localparam int N = 4, D_W = 8, K_MAX = 256, AW = 8;
`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
  localparam int TO = 20;
`else
  localparam int TO = 1024;
`endif

  logic             clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [8:0]       k_len = '0;
  logic             rd_en, busy, done, err;
  logic [AW-1:0]    a_addr, b_addr;
  logic [N*D_W-1:0] a_rd_data = '1, b_rd_data = '1;
  logic [N*D_W-1:0] a_edge, b_edge;
  logic [N*N-1:0]   init_vec;
  logic [N-1:0]     res_valid = '0;

  logic [D_W-1:0] a_mem [0:K_MAX-1][0:N-1];
  logic [D_W-1:0] b_mem [0:K_MAX-1][0:N-1];
  int checks = 0, failures = 0;

  systolic_seq_ctrl #(.D_W(D_W), .N(N), .K_MAX(K_MAX), .AW(AW), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .a_edge(a_edge), .b_edge(b_edge), .init_vec(init_vec),
    .res_valid(res_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // synchronous operand RAMs, one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < N; i++) begin
        a_rd_data[i*D_W +: D_W] <= a_mem[a_addr][i];
        b_rd_data[i*D_W +: D_W] <= b_mem[b_addr][i];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode, input int K);
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        case (mode)
          1:       begin a_mem[k][i] = 8'd1;       b_mem[k][i] = 8'd2;       end
          2:       begin a_mem[k][i] = D_W'(k);    b_mem[k][i] = D_W'(k);    end
          default: begin a_mem[k][i] = D_W'($urandom_range(1, 255));
                         b_mem[k][i] = D_W'($urandom_range(1, 255)); end
        endcase
      end
  endtask

  // lane i shows element k in cycle 3+k+i, zero elsewhere
  function automatic logic [N*D_W-1:0] exp_edge(input bit is_b, input int c, input int K);
    logic [N*D_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = c - 3 - i;
      if (k >= 0 && k < K) v[i*D_W +: D_W] = is_b ? b_mem[k][i] : a_mem[k][i];
    end
    return v;
  endfunction

  function automatic logic [N*N-1:0] exp_init(input int c, input int K);
    logic [N*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (K > 0 && (c == 3 + i + j || c == 3 + K + i + j)) v[i*N+j] = 1'b1;
    return v;
  endfunction

  task automatic check_cycle(input int c, input int K, input int done_c, input int err_c);
    bit exp_rd;
    exp_rd = (c >= 1 && c <= K);
    check_eq($sformatf("c%0d_rd_en", c), 64'(rd_en), 64'(exp_rd));
    if (exp_rd) begin
      check_eq($sformatf("c%0d_a_addr", c), 64'(a_addr), 64'(c - 1));
      check_eq($sformatf("c%0d_b_addr", c), 64'(b_addr), 64'(c - 1));
    end
    check_eq($sformatf("c%0d_a_edge", c), 64'(a_edge), 64'(exp_edge(1'b0, c, K)));
    check_eq($sformatf("c%0d_b_edge", c), 64'(b_edge), 64'(exp_edge(1'b1, c, K)));
    check_eq($sformatf("c%0d_init", c), 64'(init_vec), 64'(exp_init(c, K)));
    check_eq($sformatf("c%0d_busy", c), 64'(busy), 64'(done_c == 0 || c <= done_c));
    check_eq($sformatf("c%0d_done", c), 64'(done), 64'(c == done_c));
    check_eq($sformatf("c%0d_err", c), 64'(err), 64'(c == err_c));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_en"}, 64'(rd_en), 64'(0));
    check_eq({tag, "_addr"}, 64'({a_addr, b_addr}), 64'(0));
    check_eq({tag, "_edges"}, 64'({a_edge, b_edge}), 64'(0));
    check_eq({tag, "_init"}, 64'(init_vec), 64'(0));
    check_eq({tag, "_flags"}, 64'({busy, done, err}), 64'(0));
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_all_zero(tag);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // one job: model predicts every output per cycle from K, RAM contents and the res_valid it drives
  task automatic run_job(input int K, input int mode, input bit hold_zero);
    int done_c, err_c, cnt, limit, last_c;
    logic [N-1:0] rv;
    fill(mode, K);
    start = 1'b1; k_len = 9'(K); res_valid = '0;
    @(posedge clk); #1;
    start = 1'b0;
    done_c = (K == 0) ? 1 : 0; err_c = 0; cnt = 0; limit = K + 200; last_c = 0;
    if (hold_zero) begin
`ifdef SYS_SEQ_CTRL_WATCHDOG_EN
      err_c = K + TO + 1; done_c = K + TO + 2;
`else
      limit = K + 60;
`endif
    end
    for (int c = 1; c <= limit; c++) begin
      last_c = c;
      check_cycle(c, K, done_c, err_c);
      if (done_c != 0 && c == done_c + 2) break;
      rv = hold_zero ? '0 : N'($urandom_range(0, 15));
      if (!hold_zero && done_c == 0 && c >= K + 3) begin
        cnt += $countones(rv);
        if (cnt >= N*N) done_c = c + 1;
      end
      if (done_c == 0 || c <= done_c) begin
        start = ($urandom_range(0, 3) == 0);
        k_len = 9'($urandom_range(0, K_MAX));
      end else begin
        start = 1'b0;
      end
      res_valid = rv;
      @(posedge clk); #1;
    end
    start = 1'b0; res_valid = '0;
    $display("job K=%0d mode=%0d hold_zero=%0d done_cycle=%0d last_cycle=%0d", K, mode, hold_zero, done_c, last_c);
    if (hold_zero && done_c == 0) begin
      check_eq("stuck_busy", 64'(busy), 64'(1));
      async_reset("wd_off_reset");
    end
  endtask

  initial begin
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_job(3, 1, 1'b0);
    run_job(4, 2, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(1, 0, 1'b0);

    // reset mid-FETCH in cycle 2
    fill(0, 5);
    start = 1'b1; k_len = 9'd5;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_rd_en", 64'(rd_en), 64'(1));
    check_eq("pre_rst_addr", 64'(a_addr), 64'(1));
    async_reset("mid_fetch");
    run_job(5, 0, 1'b0);

    for (int t = 0; t < 8; t++) run_job($urandom_range(1, 12), 0, 1'b0);
    run_job($urandom_range(20, 40), 0, 1'b0);

    run_job(2, 0, 1'b1);
    run_job(3, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
